// File: rtl/kpd_emu_pkg.sv
// ============================================================================
// Module      : kpd_emu_pkg
// Description : Shared types and constants for the 4x4 keypad emulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kpd_emu_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HELD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        GAP            = 3'd4
    } kpd_emu_state_t;

    // Row/column indices are bit positions in rows/columns (bit 3 = row 1 / column 1).
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } kpd_pos_t;

    // Entries listed from key F down to key 0.
    localparam kpd_pos_t [15:0] KEY_TABLE = 64'h1304_8C56_79AB_DEF2;

    // Feedback taps q[7]^q[5]^q[4]^q[3].
    localparam logic [7:0] LFSR_TAP_MASK     = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

    function automatic kpd_pos_t key_pos(input logic [3:0] code);
        return KEY_TABLE[code];
    endfunction

endpackage

`default_nettype wire

// File: rtl/kpd_bounce_lfsr.sv
// ============================================================================
// Module      : kpd_bounce_lfsr
// Description : 8-bit Fibonacci LFSR (shift left) supplying contact bounce bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kpd_bounce_lfsr
    import kpd_emu_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic step,
    output logic bit_out
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (step) begin
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAP_MASK)};
        end
    end

    assign bit_out = r_q[0];

endmodule

`default_nettype wire

// File: rtl/keypad_emulator.sv
// ============================================================================
// Module      : keypad_emulator
// Description : Keypad end of a 4x4 row/column scan; presses a requested key
//               for a programmed hold time. KPD_BOUNCE_EN adds contact bounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_emulator
    import kpd_emu_pkg::*;
#(
    parameter int         BOUNCE_CYCLES = 16,
    parameter int         GAP_CYCLES    = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_code,
    input  logic [15:0] hold_cycles,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [3:0]  rows,
    output logic [3:0]  columns,
    output logic        busy,
    output logic        contact
);

    kpd_emu_state_t r_state, w_state_next;
    logic [15:0]    r_count, w_count_next;
    logic [3:0]     r_code,  w_code_next;
    logic [15:0]    w_hold_eff;
    kpd_pos_t       w_pos;

    assign w_hold_eff = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;

`ifdef KPD_BOUNCE_EN
    logic [15:0] r_hold, w_hold_next;
    logic        w_lfsr_load;
    logic        w_lfsr_step;
    logic        w_lfsr_bit;

    kpd_bounce_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (w_lfsr_load),
        .step    (w_lfsr_step),
        .bit_out (w_lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= 16'd0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= 16'd0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_code  <= w_code_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_code_next  = r_code;
`ifdef KPD_BOUNCE_EN
        w_hold_next  = r_hold;
        w_lfsr_load  = 1'b0;
        w_lfsr_step  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_code_next  = key_code;
`ifdef KPD_BOUNCE_EN
                    w_hold_next  = w_hold_eff;
                    w_state_next = PRESS_BOUNCE;
                    w_count_next = 16'(BOUNCE_CYCLES - 1);
                    w_lfsr_load  = 1'b1;
`else
                    w_state_next = HELD;
                    w_count_next = w_hold_eff - 16'd1;
`endif
                end
            end
`ifdef KPD_BOUNCE_EN
            PRESS_BOUNCE: begin
                w_lfsr_step = 1'b1;
                if (r_count == 16'd0) begin
                    w_state_next = HELD;
                    w_count_next = r_hold - 16'd1;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            HELD: begin
                if (r_count == 16'd0) begin
                    w_state_next = RELEASE_BOUNCE;
                    w_count_next = 16'(BOUNCE_CYCLES - 1);
                    w_lfsr_load  = 1'b1;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            RELEASE_BOUNCE: begin
                w_lfsr_step = 1'b1;
                if (r_count == 16'd0) begin
                    w_state_next = GAP;
                    w_count_next = 16'(GAP_CYCLES - 1);
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
`else
            HELD: begin
                if (r_count == 16'd0) begin
                    w_state_next = GAP;
                    w_count_next = 16'(GAP_CYCLES - 1);
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
`endif
            GAP: begin
                if (r_count == 16'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = 16'd0;
            end
        endcase
    end

    // Contact is decoded only from registers, so it moves solely on clock edges.
    always_comb begin
        contact = 1'b0;
        case (r_state)
            HELD: contact = 1'b1;
`ifdef KPD_BOUNCE_EN
            PRESS_BOUNCE, RELEASE_BOUNCE: contact = w_lfsr_bit;
`endif
            default: contact = 1'b0;
        endcase
    end

    assign w_pos = key_pos(r_code);

    always_comb begin
        columns            = 4'b1111;
        columns[w_pos.col] = ~(contact & rows[w_pos.row]);
    end

    assign key_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench for keypad_emulator; follows KPD_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_emulator;

    localparam int         B    = 16;
    localparam int         G    = 8;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_code;
    logic [15:0] hold_cycles;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  rows;
    logic [3:0]  columns;
    logic        busy;
    logic        contact;

    int tests = 0;
    int fails = 0;

    int LAYOUT [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    keypad_emulator #(
        .BOUNCE_CYCLES (B),
        .GAP_CYCLES    (G),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_code    (key_code),
        .hold_cycles (hold_cycles),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .rows        (rows),
        .columns     (columns),
        .busy        (busy),
        .contact     (contact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounce bit k of a phase: seed stepped k times by the spec's feedback rule.
    function automatic logic bounce_bit(input int k);
        logic [7:0] q;
        q = SEED;
        for (int i = 0; i < k; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        return q[0];
    endfunction

    // Expected columns from the physical layout: row n -> rows[4-n], column n -> columns[4-n].
    function automatic logic [3:0] exp_cols(input logic [3:0] code, input logic c, input logic [3:0] rw);
        logic [3:0] res;
        res = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (LAYOUT[r][cc] == int'(code) && c && rw[3-r]) res[3-cc] = 1'b0;
        return res;
    endfunction

    // One full press; rows_fix < 0 means fresh random rows every cycle.
    task automatic do_press(input logic [3:0] code, input logic [15:0] hold, input int rows_fix);
        logic q[$];
        int   h;
        h = (hold == 16'd0) ? 1 : int'(hold);
`ifdef KPD_BOUNCE_EN
        for (int k = 0; k < B; k++) q.push_back(bounce_bit(k));
`endif
        for (int k = 0; k < h; k++) q.push_back(1'b1);
`ifdef KPD_BOUNCE_EN
        for (int k = 0; k < B; k++) q.push_back(bounce_bit(k));
`endif
        for (int k = 0; k < G; k++) q.push_back(1'b0);

        @(negedge clk);
        check("ready_before_req", {31'd0, key_ready}, 32'd1);
        key_code    = code;
        hold_cycles = hold;
        key_valid   = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rows = (rows_fix < 0) ? 4'($urandom) : 4'(rows_fix);
            #1;
            check("contact", {31'd0, contact}, {31'd0, q[i]});
            check("columns", {28'd0, columns}, {28'd0, exp_cols(code, q[i], rows)});
            check("busy", {31'd0, busy}, 32'd1);
            check("ready_low", {31'd0, key_ready}, 32'd0);
            // Requests while busy must be ignored; inputs may change freely.
            key_valid   = 1'($urandom);
            key_code    = 4'($urandom);
            hold_cycles = 16'($urandom_range(0, 40));
        end
        @(negedge clk);
        key_valid = 1'b0;
        rows      = 4'b1111;
        #1;
        check("ready_after", {31'd0, key_ready}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("cols_after", {28'd0, columns}, 32'hF);
    endtask

    initial begin
        logic [3:0] rot;
        reset       = 1'b0;
        key_code    = 4'd0;
        hold_cycles = 16'd0;
        key_valid   = 1'b0;
        rows        = 4'b1000;

        rot = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rows = rot;
            rot  = {rot[0], rot[3:1]};
            #1;
            check("rst_columns", {28'd0, columns}, 32'hF);
            check("rst_ready", {31'd0, key_ready}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        do_press(4'h5, 16'd10, 4);
        do_press(4'h5, 16'd10, 8);
        do_press(4'hD, 16'd10, 1);
        do_press(4'h1, 16'd20, 8);
        do_press(4'h9, 16'd0, 2);
        for (int n = 0; n < 6; n++)
            do_press(4'($urandom), 16'($urandom_range(0, 30)), -1);

        // Reset mid-hold with a simultaneous request: reset wins.
        @(negedge clk);
        key_code    = 4'h7;
        hold_cycles = 16'd30;
        key_valid   = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        rows      = 4'b0010;
`ifdef KPD_BOUNCE_EN
        repeat (B + 5) @(negedge clk);
`else
        repeat (5) @(negedge clk);
`endif
        #1;
        check("held_contact", {31'd0, contact}, 32'd1);
        check("held_columns", {28'd0, columns}, 32'h7);
        reset     = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'h3;
        @(negedge clk);
        #1;
        check("rstheld_ready", {31'd0, key_ready}, 32'd1);
        check("rstheld_busy", {31'd0, busy}, 32'd0);
        check("rstheld_cols", {28'd0, columns}, 32'hF);
        check("rstheld_contact", {31'd0, contact}, 32'd0);
        reset     = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        #1;
        check("req_dropped", {31'd0, busy}, 32'd0);

        do_press(4'hC, 16'd3, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
